// File: rtl/spi_txn_bridge.sv
// rtl/spi_txn_bridge.sv - turns one SPI register transaction into a single peripheral bus access
module spi_txn_bridge #(
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [31:0]       spi_wdata,
  input  logic              spi_addr_v,
  input  logic              spi_data_dv,
  input  logic              spi_rw,
  input  logic [1:0]        spi_txn_w,
  output logic [31:0]       spi_rdata,
  output logic              spi_rdata_v,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [31:0]       data_out,
  input  logic              data_ready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  addr_v_q, data_dv_q;
  logic [ADDR_W-1:0]     address_q, address_d;
  logic [31:0]           data_in_q, data_in_d;
  logic [1:0]            width_q, width_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rdata_v_q, rdata_v_d;
  logic [1:0]            write_n_q, write_n_d;
  logic [1:0]            read_n_q, read_n_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]  cnt_inc;
  logic                  addr_v_rise, data_dv_rise;

  assign addr_v_rise  = spi_addr_v & ~addr_v_q;
  assign data_dv_rise = spi_data_dv & ~data_dv_q;
  assign cnt_inc      = cnt_q + TIMEOUT_W'(1);

  function automatic logic [31:0] mask_data(input logic [31:0] d, input logic [1:0] w);
    case (w)
      2'b00:   mask_data = {24'h0, d[7:0]};
      2'b01:   mask_data = {16'h0, d[15:0]};
      default: mask_data = d;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    data_in_d = data_in_q;
    width_d   = width_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rdata_v_d = 1'b0;
    write_n_d = 2'b11;
    read_n_d  = read_n_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        // spi_rw decides which of two simultaneous edges is honoured
        if (data_dv_rise && spi_rw && spi_txn_w != 2'b11) begin
          address_d = spi_addr;
          data_in_d = spi_wdata;
          width_d   = spi_txn_w;
          err_d     = 1'b0;
          state_d   = WRITE;
        end else if (addr_v_rise && !spi_rw && spi_txn_w != 2'b11) begin
          address_d = spi_addr;
          width_d   = spi_txn_w;
          err_d     = 1'b0;
          read_n_d  = spi_txn_w;
          cnt_d     = '0;
          state_d   = READ_WAIT;
        end
      end
      WRITE: begin
        write_n_d = width_q;
        state_d   = IDLE;
      end
      READ_WAIT: begin
        if (data_ready) begin
          rdata_d   = mask_data(data_out, width_q);
          read_n_d  = 2'b11;
          rdata_v_d = 1'b1;
          state_d   = RESP;
        end else if (&cnt_inc) begin
          rdata_d   = 32'hFFFF_FFFF;
          err_d     = 1'b1;
          read_n_d  = 2'b11;
          rdata_v_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_v_q  <= 1'b0;
      data_dv_q <= 1'b0;
      address_q <= '0;
      data_in_q <= '0;
      width_q   <= 2'b00;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rdata_v_q <= 1'b0;
      write_n_q <= 2'b11;
      read_n_q  <= 2'b11;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_v_q  <= spi_addr_v;
      data_dv_q <= spi_data_dv;
      address_q <= address_d;
      data_in_q <= data_in_d;
      width_q   <= width_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rdata_v_q <= rdata_v_d;
      write_n_q <= write_n_d;
      read_n_q  <= read_n_d;
      cnt_q     <= cnt_d;
    end
  end

  assign spi_rdata    = rdata_q;
  assign spi_rdata_v  = rdata_v_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign address      = address_q;
  assign data_in      = data_in_q;
  assign data_write_n = write_n_q;
  assign data_read_n  = read_n_q;

endmodule

// File: tb/tb_spi_txn_bridge.sv
// tb/tb_spi_txn_bridge.sv - scoreboard bench for spi_txn_bridge with directed vectors
module tb_spi_txn_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  spi_addr = '0;
  logic [31:0] spi_wdata = '0;
  logic        spi_addr_v = 1'b0;
  logic        spi_data_dv = 1'b0;
  logic        spi_rw = 1'b0;
  logic [1:0]  spi_txn_w = 2'b11;
  logic [31:0] spi_rdata;
  logic        spi_rdata_v;
  logic        busy;
  logic        err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out = '0;
  logic        data_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  logic [5:0]  exp_waddr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [1:0]  exp_wstrb_q[$];

  spi_txn_bridge #(.ADDR_W(6), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_addr_v(spi_addr_v), .spi_data_dv(spi_data_dv),
    .spi_rw(spi_rw), .spi_txn_w(spi_txn_w),
    .spi_rdata(spi_rdata), .spi_rdata_v(spi_rdata_v),
    .busy(busy), .err(err),
    .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w,
                          input bit both_edges, input int hold);
    spi_addr = a; spi_wdata = d; spi_txn_w = w; spi_rw = 1'b1;
    spi_data_dv = 1'b1;
    if (both_edges) spi_addr_v = 1'b1;
    exp_waddr_q.push_back(a); exp_wdata_q.push_back(d); exp_wstrb_q.push_back(w);
    tick(1);
    check("write_busy", {31'b0, busy}, 32'd1);
    check("write_err_clr", {31'b0, err}, 32'd0);
    tick(1);
    check("write_busy_drop", {31'b0, busy}, 32'd0);
    tick(hold);
    spi_data_dv = 1'b0; spi_addr_v = 1'b0;
    tick(1);
  endtask

  task automatic do_read(input string name, input logic [5:0] a, input logic [1:0] w,
                         input logic [31:0] dout, input int delay,
                         input logic [31:0] exp_rd, input logic exp_e, input int exp_cycles);
    int cnt;
    spi_addr = a; spi_txn_w = w; spi_rw = 1'b0; data_out = dout;
    spi_addr_v = 1'b1;
    exp_rdata_q.push_back(exp_rd); exp_err_q.push_back(exp_e);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (data_read_n == w) cnt++;
      else if (cnt > 0 || data_read_n != 2'b11) break;
      if (delay >= 0 && cnt == delay + 1) data_ready = 1'b1;
    end
    data_ready = 1'b0; spi_addr_v = 1'b0;
    check({name, "_read_cycles"}, cnt, exp_cycles);
    tick(2);
    check({name, "_addr"}, {26'b0, address}, {26'b0, a});
  endtask

  initial begin
    tick(2);
    check("rst_rdata", spi_rdata, 32'h0);
    check("rst_rdata_v", {31'b0, spi_rdata_v}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_address", {26'b0, address}, 32'd0);
    check("rst_data_in", data_in, 32'h0);
    check("rst_write_n", {30'b0, data_write_n}, 32'd3);
    check("rst_read_n", {30'b0, data_read_n}, 32'd3);
    rst = 1'b0;
    tick(2);

    fork
      forever begin
        @(negedge clk);
        if (spi_rdata_v) begin
          if (exp_rdata_q.size() == 0) check("unexpected_rdata_v", 32'd1, 32'd0);
          else begin
            check("sb_rdata", spi_rdata, exp_rdata_q.pop_front());
            check("sb_err", {31'b0, err}, {31'b0, exp_err_q.pop_front()});
          end
        end
        if (data_write_n != 2'b11) begin
          if (exp_wstrb_q.size() == 0) check("unexpected_write", {30'b0, data_write_n}, 32'd3);
          else begin
            check("sb_wstrb", {30'b0, data_write_n}, {30'b0, exp_wstrb_q.pop_front()});
            check("sb_waddr", {26'b0, address}, {26'b0, exp_waddr_q.pop_front()});
            check("sb_wdata", data_in, exp_wdata_q.pop_front());
          end
        end
      end
      begin
        do_write(6'h05, 32'hA5A5_1234, 2'b10, 1'b0, 2);
        do_read("byte", 6'h11, 2'b00, 32'hDEAD_BE7F, 3, 32'h0000_007F, 1'b0, 4);
        do_read("half", 6'h12, 2'b01, 32'h1234_5678, 0, 32'h0000_5678, 1'b0, 1);
        do_read("word", 6'h13, 2'b10, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0, 2);
        do_read("tmo", 6'h3F, 2'b10, 32'h1111_1111, -1, 32'hFFFF_FFFF, 1'b1, 15);
        check("err_sticky", {31'b0, err}, 32'd1);

        spi_txn_w = 2'b11; spi_rw = 1'b1; spi_data_dv = 1'b1;
        tick(1);
        check("none_busy", {31'b0, busy}, 32'd0);
        tick(3);
        check("none_err_kept", {31'b0, err}, 32'd1);
        spi_data_dv = 1'b0;
        tick(1);

        do_write(6'h2A, 32'h0BAD_F00D, 2'b00, 1'b0, 20);
        check("err_cleared", {31'b0, err}, 32'd0);
        do_write(6'h07, 32'h5555_AAAA, 2'b01, 1'b1, 2);

        spi_addr = 6'h21; spi_txn_w = 2'b00; spi_rw = 1'b0; spi_addr_v = 1'b1;
        tick(3);
        check("mid_read_active", {30'b0, data_read_n}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_read_n_async", {30'b0, data_read_n}, 32'd3);
        check("rst_busy_async", {31'b0, busy}, 32'd0);
        spi_addr_v = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        do_read("post_rst", 6'h22, 2'b01, 32'h89AB_CDEF, 2, 32'h0000_CDEF, 1'b0, 3);
        tick(3);
      end
    join_any
    disable fork;
    check("sb_reads_drained", exp_rdata_q.size(), 32'd0);
    check("sb_writes_drained", exp_wstrb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
